// File: rtl/dual_conf_ctrl.sv
// dual_conf_ctrl
//   Drives the MAX10 dual-configuration IP over Avalon-MM to reboot the
//   device from CFM0 or CFM1. A debounced request (or, optionally, a watchdog
//   expiry) polls the IP busy bit, writes the image select/overwrite register,
//   then writes the trigger register. DONE is terminal because the device
//   reconfigures immediately afterwards.
//
//   Optional feature: define DUAL_CONF_WATCHDOG_EN to add a kick watchdog.
//   When it expires in IDLE, the sequence starts with the CFM0 image.
//
// Ports
//   i_clk          single clock for all logic
//   i_rstn         asynchronous active-low reset
//   i_reconf_req   asynchronous request level (VIO or pushbutton)
//   i_img_sel      target image, 0 = CFM0, 1 = CFM1, sampled at acceptance
//   i_wd_kick      watchdog kick pulse (ignored without the watchdog)
//   o_avmm_addr    dual-config IP register address (0 when no strobe)
//   o_avmm_wr      single-cycle write strobe
//   o_avmm_rd      single-cycle read strobe
//   o_avmm_wdata   write data (0 when no strobe)
//   i_avmm_rdata   read data, valid 2 cycles after o_avmm_rd
//   o_busy         high in any state except IDLE and ERR
//   o_err          sticky busy-poll timeout flag
//   o_state        FSM state encoding for probing
module dual_conf_ctrl #(
  parameter int DEB_CYCLES     = 16,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int POLL_MAX       = 255,
  parameter int WD_CYCLES      = 50000000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_reconf_req,
  input  logic        i_img_sel,
  input  logic        i_wd_kick,
  output logic [2:0]  o_avmm_addr,
  output logic        o_avmm_wr,
  output logic        o_avmm_rd,
  output logic [31:0] o_avmm_wdata,
  input  logic [31:0] i_avmm_rdata,
  output logic        o_busy,
  output logic        o_err,
  output logic [2:0]  o_state
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [POLL_W-1:0] POLL_TOP  = POLL_W'(POLL_MAX);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POLL_RD   = 3'd1,
    POLL_WAIT = 3'd2,
    WR_SEL    = 3'd3,
    WR_TRIG   = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                sync_p0, sync_p1;
  logic                filt_q, filt_dly_q;
  logic [DEB_W-1:0]    deb_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic                wait_q, wait_d;
  logic                img_q, img_d;
  logic                err_q, err_d;
  logic                trig;
  logic                wd_fire;

  // Stage: synchroniser, debouncer and reset holdoff
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= HOLD_INIT;
    end else begin
      sync_p0    <= i_reconf_req;
      sync_p1    <= sync_p0;
      filt_dly_q <= filt_q;
      // The filtered level follows only after DEB_CYCLES consecutive samples
      // that disagree with it; any agreeing sample restarts the count.
      if (sync_p1 != filt_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          filt_q    <= sync_p1;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
      if (hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end
    end
  end

  // Filtered is reset to 0, so a request held through reset produces its
  // rising edge inside holdoff and must fall and rise again to be seen.
  assign trig = filt_q & ~filt_dly_q & (hold_cnt_q == '0);

`ifdef DUAL_CONF_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_TOP = WD_W'(WD_CYCLES);

  logic [WD_W-1:0] wd_cnt_q;

  // Stage: kick watchdog, held clear during holdoff, saturates at expiry
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd_cnt_q <= '0;
    end else if ((hold_cnt_q != '0) || i_wd_kick) begin
      wd_cnt_q <= '0;
    end else if (wd_cnt_q != WD_TOP) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign wd_fire = (wd_cnt_q == WD_TOP);
`else
  logic unused_wd;
  assign unused_wd = i_wd_kick;
  assign wd_fire   = 1'b0;
`endif

  logic unused_rdata;
  assign unused_rdata = ^i_avmm_rdata[31:1];

  // Stage: FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      poll_cnt_q <= '0;
      wait_q     <= 1'b0;
      img_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      wait_q     <= wait_d;
      img_q      <= img_d;
      err_q      <= err_d;
    end
  end

  // Stage: next state and bus strobes (Moore, straight from the state
  // register, so an asynchronous reset silences the bus at once)
  always_comb begin
    state_d      = state_q;
    poll_cnt_d   = poll_cnt_q;
    wait_d       = 1'b0;
    img_d        = img_q;
    err_d        = err_q;
    o_avmm_rd    = 1'b0;
    o_avmm_wr    = 1'b0;
    o_avmm_addr  = 3'd0;
    o_avmm_wdata = 32'd0;
    unique case (state_q)
      IDLE: begin
        // A manual trigger takes priority over a simultaneous expiry.
        if (trig) begin
          img_d      = i_img_sel;
          poll_cnt_d = '0;
          state_d    = POLL_RD;
        end else if (wd_fire) begin
          img_d      = 1'b0;
          poll_cnt_d = '0;
          state_d    = POLL_RD;
        end
      end
      POLL_RD: begin
        o_avmm_rd   = 1'b1;
        o_avmm_addr = 3'd3;
        state_d     = POLL_WAIT;
      end
      POLL_WAIT: begin
        // Two wait cycles: read data lands on the second one.
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (i_avmm_rdata[0]) begin
          if (poll_cnt_q >= POLL_LAST) begin
            poll_cnt_d = POLL_TOP;
            err_d      = 1'b1;
            state_d    = ERR;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            state_d    = POLL_RD;
          end
        end else begin
          state_d = WR_SEL;
        end
      end
      WR_SEL: begin
        o_avmm_wr    = 1'b1;
        o_avmm_addr  = 3'd1;
        o_avmm_wdata = {30'd0, img_q, 1'b1};
        state_d      = WR_TRIG;
      end
      WR_TRIG: begin
        o_avmm_wr    = 1'b1;
        o_avmm_addr  = 3'd0;
        o_avmm_wdata = 32'd1;
        state_d      = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      ERR: begin
        if (trig) begin
          err_d      = 1'b0;
          poll_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy  = (state_q != IDLE) && (state_q != ERR);
  assign o_err   = err_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_dual_conf_ctrl.sv
module tb_dual_conf_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int PMAX = 3;
  localparam int WD   = 100;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_reconf_req;
  logic        i_img_sel;
  logic        i_wd_kick;
  logic [2:0]  o_avmm_addr;
  logic        o_avmm_wr;
  logic        o_avmm_rd;
  logic [31:0] o_avmm_wdata;
  logic [31:0] i_avmm_rdata;
  logic        o_busy;
  logic        o_err;
  logic [2:0]  o_state;

  always #5 i_clk = ~i_clk;

  dual_conf_ctrl #(
    .DEB_CYCLES    (DEB),
    .HOLDOFF_CYCLES(HOLD),
    .POLL_MAX      (PMAX),
    .WD_CYCLES     (WD)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_reconf_req(i_reconf_req),
    .i_img_sel   (i_img_sel),
    .i_wd_kick   (i_wd_kick),
    .o_avmm_addr (o_avmm_addr),
    .o_avmm_wr   (o_avmm_wr),
    .o_avmm_rd   (o_avmm_rd),
    .o_avmm_wdata(o_avmm_wdata),
    .i_avmm_rdata(i_avmm_rdata),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_state     (o_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Bus log and busy-bit responder, sampled mid-cycle
  logic        log_clr    = 1'b0;
  int          busy_polls = 0;
  logic        busy_bit   = 1'b0;
  int          n_tx       = 0;
  int          rd_n       = 0;
  int          both_cnt   = 0;
  int          idle_bad   = 0;
  logic [35:0] tx_rec [0:31];
  int          tx_cyc [0:31];

  assign i_avmm_rdata = {31'd0, busy_bit};

  always @(negedge i_clk) begin
    if (o_avmm_rd && o_avmm_wr) both_cnt <= both_cnt + 1;
    if (!o_avmm_rd && !o_avmm_wr && (o_avmm_addr != 3'd0 || o_avmm_wdata != 32'd0))
      idle_bad <= idle_bad + 1;
    if (log_clr) begin
      n_tx <= 0;
      rd_n <= 0;
    end else begin
      if (o_avmm_rd || o_avmm_wr) begin
        if (n_tx < 32) begin
          tx_rec[n_tx] <= {o_avmm_wr, o_avmm_addr, o_avmm_wdata};
          tx_cyc[n_tx] <= cyc;
        end
        n_tx <= n_tx + 1;
      end
      if (o_avmm_rd) begin
        rd_n     <= rd_n + 1;
        busy_bit <= ((rd_n + 1) <= busy_polls);
      end
    end
  end

  // Kick generator: one pulse every 50 cycles while enabled
  logic kick_en = 1'b1;
  initial begin
    i_wd_kick = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_wd_kick = kick_en && ((cyc % 50) == 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({o_state, o_busy, o_err, o_avmm_rd, o_avmm_wr, o_avmm_addr, o_avmm_wdata}), 64'd0);
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(negedge i_clk);
    #1;
    log_clr = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    i_rstn = 1'b0;
    tick(3);
    check_reset_outputs(tag);
    i_rstn = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k;
    k = 0;
    while (o_state !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(o_state), 64'(s));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    i_rstn       = 1'b0;
    i_reconf_req = 1'b0;
    i_img_sel    = 1'b0;
    tick(2);

    // Request held through reset: its edge lands in holdoff and is ignored
    i_reconf_req = 1'b1;
    do_reset("rst_vals");
    clear_log();
    tick(25);
    check("holdoff_state", 64'(o_state), 64'd0);
    check("holdoff_no_bus", 64'(n_tx), 64'd0);

    // Drop, then raise again: full sequence to CFM1
    i_reconf_req = 1'b0;
    tick(15);
    i_img_sel    = 1'b1;
    i_reconf_req = 1'b1;
    wait_state(3'd5, 60, "seq1_done");
    check("seq1_ntx", 64'(n_tx), 64'd3);
    check("seq1_rd", 64'(tx_rec[0]), 64'({1'b0, 3'd3, 32'd0}));
    check("seq1_wrsel", 64'(tx_rec[1]), 64'({1'b1, 3'd1, 32'h3}));
    check("seq1_wrtrig", 64'(tx_rec[2]), 64'({1'b1, 3'd0, 32'h1}));
    check("seq1_busy", 64'(o_busy), 64'd1);
    tick(20);
    check("done_quiet", 64'(n_tx), 64'd3);
    check("done_stays", 64'(o_state), 64'd5);

    // 3-cycle glitch is rejected; a 4-cycle pulse is accepted
    i_reconf_req = 1'b0;
    i_img_sel    = 1'b0;
    do_reset("rst_vals2");
    tick(15);
    clear_log();
    i_reconf_req = 1'b1;
    tick(3);
    i_reconf_req = 1'b0;
    tick(15);
    check("glitch_state", 64'(o_state), 64'd0);
    check("glitch_no_bus", 64'(n_tx), 64'd0);
    i_reconf_req = 1'b1;
    tick(4);
    i_reconf_req = 1'b0;
    wait_state(3'd5, 60, "pulse4_done");
    check("pulse4_wrsel", 64'(tx_rec[1]), 64'({1'b1, 3'd1, 32'h1}));

    // Busy never clears: POLL_MAX reads then ERR
    do_reset("rst_vals3");
    tick(15);
    clear_log();
    busy_polls   = 100;
    i_reconf_req = 1'b1;
    wait_state(3'd6, 80, "err_state");
    check("err_ntx", 64'(n_tx), 64'd3);
    check("err_all_rd", 64'({tx_rec[0][35], tx_rec[1][35], tx_rec[2][35]}), 64'd0);
    check("err_flag", 64'(o_err), 64'd1);
    check("err_busy", 64'(o_busy), 64'd0);
    tick(10);
    check("err_quiet", 64'(n_tx), 64'd3);
    busy_polls   = 0;
    i_reconf_req = 1'b0;
    tick(10);
    clear_log();
    i_reconf_req = 1'b1;
    wait_state(3'd0, 20, "err_to_idle");
    check("err_cleared", 64'(o_err), 64'd0);
    i_reconf_req = 1'b0;
    tick(10);
    i_reconf_req = 1'b1;
    wait_state(3'd5, 60, "retrig_done");
    check("retrig_ntx", 64'(n_tx), 64'd3);
    check("retrig_wrsel", 64'(tx_rec[1]), 64'({1'b1, 3'd1, 32'h1}));
    check("retrig_wrtrig", 64'(tx_rec[2]), 64'({1'b1, 3'd0, 32'h1}));
    check("retrig_err", 64'(o_err), 64'd0);

    // Busy for two polls, then ready
    i_reconf_req = 1'b0;
    do_reset("rst_vals4");
    tick(15);
    clear_log();
    busy_polls   = 2;
    i_img_sel    = 1'b1;
    i_reconf_req = 1'b1;
    wait_state(3'd5, 80, "busy2_done");
    check("busy2_ntx", 64'(n_tx), 64'd5);
    check("busy2_rd3", 64'(tx_rec[2]), 64'({1'b0, 3'd3, 32'd0}));
    check("busy2_gap1", 64'(tx_cyc[1] - tx_cyc[0]), 64'd3);
    check("busy2_gap2", 64'(tx_cyc[2] - tx_cyc[1]), 64'd3);
    check("busy2_wrsel", 64'(tx_rec[3]), 64'({1'b1, 3'd1, 32'h3}));
    check("busy2_wrtrig", 64'(tx_rec[4]), 64'({1'b1, 3'd0, 32'h1}));

    // Reset asserted in WR_SEL: bus silenced at once, no trigger write
    i_reconf_req = 1'b0;
    busy_polls   = 0;
    do_reset("rst_vals5");
    tick(15);
    clear_log();
    i_reconf_req = 1'b1;
    wait_state(3'd3, 60, "midrst_wrsel");
    i_rstn = 1'b0;
    #1;
    check_reset_outputs("midrst_async");
    i_reconf_req = 1'b0;
    tick(3);
    i_rstn = 1'b1;
    tick(40);
    check("midrst_ntx", 64'(n_tx), 64'd1);
    check("midrst_state", 64'(o_state), 64'd0);

    // Watchdog: kicks keep the bus quiet; without kicks it falls back to CFM0
    do_reset("rst_vals6");
    clear_log();
    kick_en   = 1'b1;
    i_img_sel = 1'b1;
    tick(300);
    check("wd_kicked_quiet", 64'(n_tx), 64'd0);
    kick_en = 1'b0;
`ifdef DUAL_CONF_WATCHDOG_EN
    wait_state(3'd5, 300, "wd_done");
    check("wd_rd", 64'(tx_rec[0]), 64'({1'b0, 3'd3, 32'd0}));
    check("wd_wrsel", 64'(tx_rec[1]), 64'({1'b1, 3'd1, 32'h1}));
`else
    tick(300);
    check("wd_absent_state", 64'(o_state), 64'd0);
    check("wd_absent_bus", 64'(n_tx), 64'd0);
`endif

    check("rd_wr_exclusive", 64'(both_cnt), 64'd0);
    check("idle_bus_zero", 64'(idle_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
